// File: rtl/fetch_sequencer_if.sv
// Instruction-memory handshake, issue port and decoded flow-control bundle for fetch_sequencer.
// FETCH_EPC_EN adds the SIIC/RTI inputs and the epc output.
interface fetch_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [15:0]     imem_data;
  logic [15:0]     instr;
  logic            instr_valid;
  logic            stall;
  logic            HALT;
  logic            JMP;
  logic            JALR_op;
  logic            BR;
  logic            br_taken;
  logic [PC_W-1:0] rs_data;
  logic [PC_W-1:0] pc_plus2;
  logic            halted;
  logic            err;
`ifdef FETCH_EPC_EN
  logic            SIIC;
  logic            RTI;
  logic [PC_W-1:0] epc;
`endif

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_plus2, halted, err,
    input  imem_ready, imem_data, stall, HALT, JMP, JALR_op, BR, br_taken, rs_data
`ifdef FETCH_EPC_EN
    ,
    input  SIIC, RTI,
    output epc
`endif
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_plus2, halted, err,
    output imem_ready, imem_data, stall, HALT, JMP, JALR_op, BR, br_taken, rs_data
`ifdef FETCH_EPC_EN
    ,
    output SIIC, RTI,
    input  epc
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/issue front end: owns the PC, fetches one instruction at a time, then redirects or halts.
// Optional macro FETCH_EPC_EN adds SIIC/RTI handling with an EPC register.
module fetch_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef FETCH_EPC_EN
  ,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(2)
`endif
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master fb
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALTED} state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_plus2, w_tgt;
  logic [15:0]     r_instr;
  logic            w_load, w_err, w_req, w_vld, w_halted;
`ifdef FETCH_EPC_EN
  logic [PC_W-1:0] r_epc, w_epc_nxt;
`endif

  function automatic logic [PC_W-1:0] sext8(input logic [7:0] v);
    logic signed [PC_W-1:0] s;
    s = {{(PC_W-8){v[7]}}, v};
    return s;
  endfunction

  function automatic logic [PC_W-1:0] sext11(input logic [10:0] v);
    logic signed [PC_W-1:0] s;
    s = {{(PC_W-11){v[10]}}, v};
    return s;
  endfunction

  assign w_pc_plus2 = r_pc + PC_W'(2);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_err       = 1'b0;
    w_req       = 1'b0;
    w_vld       = 1'b0;
    w_halted    = 1'b0;
`ifdef FETCH_EPC_EN
    w_epc_nxt   = r_epc;
`endif
    w_tgt       = fb.rs_data + sext8(r_instr[7:0]);
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (fb.imem_ready) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_vld = 1'b1;
        // Decoder inputs only matter on the single non-stalled issue cycle
        if (!fb.stall) begin
          w_state_nxt = fb.HALT ? S_HALTED : S_FETCH;
          if (fb.HALT) begin
            w_pc_nxt = r_pc;
`ifdef FETCH_EPC_EN
          end else if (fb.SIIC) begin
            w_epc_nxt = w_pc_plus2;
            w_pc_nxt  = EXC_VECTOR;
          end else if (fb.RTI) begin
            w_pc_nxt = r_epc;
`endif
          end else if (fb.JALR_op) begin
            w_pc_nxt = {w_tgt[PC_W-1:1], 1'b0};
            w_err    = w_tgt[0];
          end else if (fb.JMP) begin
            w_pc_nxt = w_pc_plus2 + sext11(r_instr[10:0]);
          end else if (fb.BR && fb.br_taken) begin
            w_pc_nxt = w_pc_plus2 + sext8(r_instr[7:0]);
          end else begin
            w_pc_nxt = w_pc_plus2;
          end
        end
      end
      S_HALTED: w_halted = 1'b1;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
`ifdef FETCH_EPC_EN
      r_epc   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_load) r_instr <= fb.imem_data;
`ifdef FETCH_EPC_EN
      r_epc   <= w_epc_nxt;
`endif
    end
  end

  assign fb.imem_req    = w_req;
  assign fb.imem_addr   = r_pc;
  assign fb.instr       = r_instr;
  assign fb.instr_valid = w_vld;
  assign fb.pc_plus2    = w_pc_plus2;
  assign fb.halted      = w_halted;
  assign fb.err         = w_err;
`ifdef FETCH_EPC_EN
  assign fb.epc         = r_epc;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses are queued at issue and
// popped at each imem handshake; flags, pc_plus2 and held instr are checked per cycle.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] sb_addr[$];
  logic [15:0] m_pc;
  logic [15:0] m_instr;
`ifdef FETCH_EPC_EN
  logic [15:0] m_epc;
  logic        drv_siic = 1'b0;
  logic        drv_rti  = 1'b0;
`endif

  fetch_if #(.PC_W(16)) fb ();

  fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fb    (fb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_decode();
    fb.stall    = 1'b0;
    fb.HALT     = 1'b0;
    fb.JMP      = 1'b0;
    fb.JALR_op  = 1'b0;
    fb.BR       = 1'b0;
    fb.br_taken = 1'b0;
    fb.rs_data  = 16'h0;
`ifdef FETCH_EPC_EN
    fb.SIIC = 1'b0;
    fb.RTI  = 1'b0;
`endif
  endtask

  // Called right after a rising edge; leaves the bench one cycle later, #1 past the edge.
  task automatic do_reset();
    rst_n = 1'b0;
    fb.imem_ready = 1'b0;
    clr_decode();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_req",    32'(fb.imem_req),    32'd1);
    chk("rst_addr",   32'(fb.imem_addr),   32'h0);
    chk("rst_valid",  32'(fb.instr_valid), 32'd0);
    chk("rst_instr",  32'(fb.instr),       32'h0);
    chk("rst_halted", 32'(fb.halted),      32'd0);
    chk("rst_err",    32'(fb.err),         32'd0);
`ifdef FETCH_EPC_EN
    chk("rst_epc",    32'(fb.epc),         32'h0);
    m_epc = 16'h0;
`endif
    sb_addr.delete();
    sb_addr.push_back(16'h0000);
  endtask

  task automatic fetch(input logic [15:0] data, input int waits);
    logic [15:0] exp;
    for (int i = 0; i < waits; i++) begin
      fb.imem_ready = 1'b0;
      fb.JMP = 1'b1;
      fb.HALT = 1'b1;
      @(negedge clk);
      chk("wait_req",   32'(fb.imem_req),    32'd1);
      chk("wait_valid", 32'(fb.instr_valid), 32'd0);
      if (sb_addr.size() > 0) chk("wait_addr", 32'(fb.imem_addr), 32'(sb_addr[0]));
      @(posedge clk); #1;
    end
    clr_decode();
    fb.imem_ready = 1'b1;
    fb.imem_data  = data;
    @(negedge clk);
    chk("fetch_req",   32'(fb.imem_req),    32'd1);
    chk("fetch_valid", 32'(fb.instr_valid), 32'd0);
`ifdef FETCH_EPC_EN
    chk("fetch_epc",   32'(fb.epc),         32'(m_epc));
`endif
    if (sb_addr.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      exp = fb.imem_addr;
    end else begin
      exp = sb_addr.pop_front();
      chk("fetch_addr", 32'(fb.imem_addr), 32'(exp));
    end
    m_pc    = exp;
    m_instr = data;
    @(posedge clk); #1;
    fb.imem_ready = 1'b0;
    fb.imem_data  = 16'(~data);
  endtask

  task automatic issue(input logic h, input logic j, input logic jl, input logic b,
                       input logic bt, input logic [15:0] rs, input int stalls);
    logic [15:0] nxt, tgt, p2;
    logic signed [7:0]  s8;
    logic signed [10:0] s11;
    logic exp_err;
    int   i8, i11;
    fb.HALT = h; fb.JMP = j; fb.JALR_op = jl; fb.BR = b; fb.br_taken = bt; fb.rs_data = rs;
`ifdef FETCH_EPC_EN
    fb.SIIC = drv_siic; fb.RTI = drv_rti;
`endif
    p2 = m_pc + 16'd2;
    for (int i = 0; i < stalls; i++) begin
      fb.stall = 1'b1;
      fb.imem_ready = 1'b1;
      @(negedge clk);
      chk("stall_valid",  32'(fb.instr_valid), 32'd1);
      chk("stall_req",    32'(fb.imem_req),    32'd0);
      chk("stall_err",    32'(fb.err),         32'd0);
      chk("stall_halted", 32'(fb.halted),      32'd0);
      chk("stall_instr",  32'(fb.instr),       32'(m_instr));
      chk("stall_pcp2",   32'(fb.pc_plus2),    32'(p2));
      @(posedge clk); #1;
    end
    fb.stall = 1'b0;
    fb.imem_ready = 1'b0;
    s8 = m_instr[7:0];  i8 = s8;
    s11 = m_instr[10:0]; i11 = s11;
    exp_err = 1'b0;
    if (h) nxt = m_pc;
`ifdef FETCH_EPC_EN
    else if (drv_siic) begin nxt = 16'h0002; m_epc = p2; end
    else if (drv_rti) nxt = m_epc;
`endif
    else if (jl) begin
      tgt = 16'(int'(rs) + i8);
      exp_err = tgt[0];
      nxt = tgt & 16'hFFFE;
    end
    else if (j) nxt = 16'(int'(m_pc) + 2 + i11);
    else if (b && bt) nxt = 16'(int'(m_pc) + 2 + i8);
    else nxt = p2;
    @(negedge clk);
    chk("issue_valid",  32'(fb.instr_valid), 32'd1);
    chk("issue_req",    32'(fb.imem_req),    32'd0);
    chk("issue_instr",  32'(fb.instr),       32'(m_instr));
    chk("issue_pcp2",   32'(fb.pc_plus2),    32'(p2));
    chk("issue_err",    32'(fb.err),         32'(exp_err));
    chk("issue_halted", 32'(fb.halted),      32'd0);
    if (!h) sb_addr.push_back(nxt);
    @(posedge clk); #1;
    clr_decode();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    fb.imem_ready = 1'b0;
    fb.imem_data  = 16'h0;
    clr_decode();
    @(posedge clk); #1;

    // Straight-line NOPs at 0, 2, 4
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fetch(16'h0800, 0);
      issue(0, 0, 0, 0, 0, 16'h0, 0);
    end

    // imem wait states at address 0
    do_reset();
    fetch(16'h0800, 3);
    issue(0, 0, 0, 0, 0, 16'h0, 0);

    // JMP to 0x10, JMP -2 loops to itself (with stall), BR not taken, BR taken backwards
    fetch(16'h200C, 0);
    issue(0, 1, 0, 0, 0, 16'h0, 0);
    fetch(16'h27FE, 0);
    issue(0, 1, 0, 0, 0, 16'h0, 2);
    fetch(16'h6010, 0);
    issue(0, 0, 0, 1, 0, 16'h0, 0);
    fetch(16'h60FC, 0);
    issue(0, 0, 0, 1, 1, 16'h0, 0);

    // JALR: odd target raises err, negative offset, then wrap of pc_plus2 at 0xFFFE
    fetch(16'h3800, 0);
    issue(0, 0, 1, 0, 0, 16'h0101, 1);
    fetch(16'h38FE, 0);
    issue(0, 0, 1, 0, 0, 16'h0200, 0);
    fetch(16'h3800, 0);
    issue(0, 0, 1, 0, 0, 16'hFFFE, 0);
    fetch(16'h0800, 0);
    issue(0, 0, 0, 0, 0, 16'h0, 0);

    // HALT held off by stall, then sticky until reset
    fetch(16'h0000, 1);
    issue(1, 0, 0, 0, 0, 16'h0, 2);
    for (int k = 0; k < 4; k++) begin
      fb.imem_ready = k[0];
      @(negedge clk);
      chk("halt_halted", 32'(fb.halted),      32'd1);
      chk("halt_req",    32'(fb.imem_req),    32'd0);
      chk("halt_valid",  32'(fb.instr_valid), 32'd0);
      @(posedge clk); #1;
    end
    do_reset();

    // Reset during ISSUE discards the fetched instruction
    fetch(16'hABCD, 0);
    do_reset();
    fetch(16'h0800, 0);
    issue(0, 0, 0, 0, 0, 16'h0, 0);

`ifdef FETCH_EPC_EN
    // SIIC from 0x40 vectors to 0x0002 and saves 0x42; RTI returns there
    do_reset();
    fetch(16'h203E, 0);
    issue(0, 1, 0, 0, 0, 16'h0, 0);
    fetch(16'h8000, 0);
    drv_siic = 1'b1;
    issue(0, 0, 1, 0, 0, 16'h0101, 0);
    drv_siic = 1'b0;
    fetch(16'h8800, 0);
    drv_rti = 1'b1;
    issue(0, 0, 0, 0, 0, 16'h0, 0);
    drv_rti = 1'b0;
    fetch(16'h0800, 0);
    issue(0, 0, 0, 0, 0, 16'h0, 0);
`endif

    // Drain: the last queued address must be the one presented next
    fetch(16'h0800, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
